// File: rtl/pkt_rx_pkg.sv
// Shared types and defaults for the MAC receive reader: FSM states, the buffered
// word record and the byte-count helpers used on the length path.
package pkt_rx_pkg;

   localparam int PKT_MIN_LEN = 64;
   localparam int PKT_MAX_LEN = 1518;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_READ = 1'b1
   } rx_state_e;

   typedef struct packed {
      logic [63:0] data;
      logic        sop;
      logic        eop;
      logic        err;
      logic [2:0]  mod;
   } rx_word_t;

   // A mod of zero on the last word means a full 8-byte word.
   function automatic logic [3:0] eop_bytes(input logic [2:0] mod_i);
      return (mod_i == 3'd0) ? 4'd8 : {1'b0, mod_i};
   endfunction

   function automatic logic [15:0] sat_add16(input logic [15:0] a_i, input logic [3:0] b_i);
      logic [16:0] sum;
      sum = {1'b0, a_i} + {13'd0, b_i};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/pkt_rx_fifo.sv
// Small synchronous FIFO of receive words; the head word is presented straight
// from storage so a write is visible on the output the following cycle.
module pkt_rx_fifo
   import pkt_rx_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          wr_en_i,
   input  rx_word_t      wr_word_i,
   input  logic          rd_en_i,
   output rx_word_t      rd_word_o,
   output logic          rd_valid_o,
   output logic [AW:0]   count_o
);

   localparam logic [AW:0]   FULL    = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   rx_word_t      mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_rd_s;
   logic          do_wr_s;

   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign do_rd_s = rd_en_i & (count_q != '0);
   assign do_wr_s = wr_en_i & ((count_q != FULL) | do_rd_s);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_wr_s) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (do_rd_s) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         case ({do_wr_s, do_rd_s})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_wr_s) begin
         mem_q[wr_ptr_q] <= wr_word_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!wr_en_i || do_wr_s);
      end
   end

   assign rd_valid_o = (count_q != '0);
   assign rd_word_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;
   assign count_o    = count_q;

endmodule

// File: rtl/pkt_rx_reader.sv
// pkt_rx_reader: pulls frames from the MAC receive queue, checks framing and
// length, and re-presents the words on a valid/ready stream with statistics.
module pkt_rx_reader
   import pkt_rx_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int MIN_LEN    = PKT_MIN_LEN,
   parameter int MAX_LEN    = PKT_MAX_LEN
) (
   input  logic        clk_156m25,
   input  logic        reset_156m25,
   input  logic        pkt_rx_avail,
   input  logic [63:0] pkt_rx_data,
   input  logic        pkt_rx_val,
   input  logic        pkt_rx_sop,
   input  logic        pkt_rx_eop,
   input  logic        pkt_rx_err,
   input  logic [2:0]  pkt_rx_mod,
   output logic        pkt_rx_ren,
   output logic [63:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_sop,
   output logic        out_eop,
   output logic        out_err,
   output logic [2:0]  out_mod,
   output logic [31:0] stat_pkt_cnt,
   output logic [31:0] stat_err_cnt,
   output logic [31:0] stat_drop_cnt,
   output logic [15:0] stat_last_len
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   rx_state_e     state_q, state_d;
   logic          in_pkt_q, in_pkt_d;
   logic [15:0]   byte_cnt_q, byte_cnt_d;
   logic [31:0]   pkt_cnt_q, pkt_cnt_d;
   logic [31:0]   err_cnt_q, err_cnt_d;
   logic [31:0]   drop_cnt_q, drop_cnt_d;
   logic [15:0]   last_len_q, last_len_d;

   logic [CW-1:0] fifo_count_s;
   logic [CW-1:0] free_s;
   logic          free_ok_s;
   logic          rx_last_s;
   logic          wr_en_s;
   logic          drop_s;
   logic [15:0]   frame_len_s;
   logic          len_bad_s;
   rx_word_t      wr_word_s;
   rx_word_t      rd_word_s;
   logic          rd_valid_s;

   // Two free slots cover the word already requested but not yet returned.
   assign free_s     = CW'(FIFO_DEPTH) - fifo_count_s;
   assign free_ok_s  = (free_s >= CW'(2));
   assign rx_last_s  = pkt_rx_val & pkt_rx_eop;
   assign pkt_rx_ren = (state_q == ST_READ) & free_ok_s & ~rx_last_s;

   assign frame_len_s = sat_add16(pkt_rx_sop ? 16'd0 : byte_cnt_q,
                                  pkt_rx_eop ? eop_bytes(pkt_rx_mod) : 4'd8);
   assign len_bad_s   = (frame_len_s < 16'(MIN_LEN)) | (frame_len_s > 16'(MAX_LEN));

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (pkt_rx_avail && free_ok_s) begin
               state_d = ST_READ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            if (rx_last_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_READ;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A sop always opens a frame, even over an unfinished one; an orphan word is discarded.
   always_comb begin
      in_pkt_d   = in_pkt_q;
      byte_cnt_d = byte_cnt_q;
      wr_en_s    = 1'b0;
      drop_s     = 1'b0;
      if (pkt_rx_val) begin
         if (pkt_rx_sop || in_pkt_q) begin
            wr_en_s    = 1'b1;
            drop_s     = pkt_rx_sop & in_pkt_q;
            byte_cnt_d = frame_len_s;
            in_pkt_d   = ~pkt_rx_eop;
         end else begin
            drop_s = 1'b1;
         end
      end else begin
         in_pkt_d = in_pkt_q;
      end
   end

   always_comb begin
      wr_word_s.data = pkt_rx_data;
      wr_word_s.sop  = pkt_rx_sop;
      wr_word_s.eop  = pkt_rx_eop;
      wr_word_s.err  = pkt_rx_eop & (pkt_rx_err | len_bad_s);
      wr_word_s.mod  = pkt_rx_eop ? pkt_rx_mod : 3'd0;
   end

   always_comb begin
      pkt_cnt_d  = pkt_cnt_q;
      err_cnt_d  = err_cnt_q;
      drop_cnt_d = drop_cnt_q;
      last_len_d = last_len_q;
      if (wr_en_s && pkt_rx_eop) begin
         pkt_cnt_d  = pkt_cnt_q + 32'd1;
         last_len_d = frame_len_s;
         if (wr_word_s.err) begin
            err_cnt_d = err_cnt_q + 32'd1;
         end else begin
            err_cnt_d = err_cnt_q;
         end
      end else begin
         pkt_cnt_d = pkt_cnt_q;
      end
      if (drop_s) begin
         drop_cnt_d = drop_cnt_q + 32'd1;
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
   end

   always_ff @(posedge clk_156m25) begin
      if (reset_156m25) begin
         state_q    <= ST_IDLE;
         in_pkt_q   <= 1'b0;
         byte_cnt_q <= 16'd0;
         pkt_cnt_q  <= 32'd0;
         err_cnt_q  <= 32'd0;
         drop_cnt_q <= 32'd0;
         last_len_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         in_pkt_q   <= in_pkt_d;
         byte_cnt_q <= byte_cnt_d;
         pkt_cnt_q  <= pkt_cnt_d;
         err_cnt_q  <= err_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         last_len_q <= last_len_d;
      end
   end

   pkt_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i      (clk_156m25),
      .rst_i      (reset_156m25),
      .wr_en_i    (wr_en_s),
      .wr_word_i  (wr_word_s),
      .rd_en_i    (out_ready),
      .rd_word_o  (rd_word_s),
      .rd_valid_o (rd_valid_s),
      .count_o    (fifo_count_s)
   );

   assign out_valid     = rd_valid_s;
   assign out_data      = rd_word_s.data;
   assign out_sop       = rd_word_s.sop;
   assign out_eop       = rd_word_s.eop;
   assign out_err       = rd_word_s.err;
   assign out_mod       = rd_word_s.mod;
   assign stat_pkt_cnt  = pkt_cnt_q;
   assign stat_err_cnt  = err_cnt_q;
   assign stat_drop_cnt = drop_cnt_q;
   assign stat_last_len = last_len_q;

endmodule

// File: tb/tb_pkt_rx_reader.sv
// Bench for pkt_rx_reader: a MAC model serves whole frames on read enable and a
// frame-level scoreboard predicts every output word and statistic.
module tb_pkt_rx_reader;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        avail;
   logic [63:0] rx_data;
   logic        rx_val, rx_sop, rx_eop, rx_err;
   logic [2:0]  rx_mod;
   logic        ren;
   logic [63:0] out_data;
   logic        out_valid, out_ready, out_sop, out_eop, out_err;
   logic [2:0]  out_mod;
   logic [31:0] stat_pkt_cnt, stat_err_cnt, stat_drop_cnt;
   logic [15:0] stat_last_len;

   always #5 clk = ~clk;

   pkt_rx_reader #(.FIFO_DEPTH(DEPTH)) dut (
      .clk_156m25    (clk),
      .reset_156m25  (reset),
      .pkt_rx_avail  (avail),
      .pkt_rx_data   (rx_data),
      .pkt_rx_val    (rx_val),
      .pkt_rx_sop    (rx_sop),
      .pkt_rx_eop    (rx_eop),
      .pkt_rx_err    (rx_err),
      .pkt_rx_mod    (rx_mod),
      .pkt_rx_ren    (ren),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_sop       (out_sop),
      .out_eop       (out_eop),
      .out_err       (out_err),
      .out_mod       (out_mod),
      .stat_pkt_cnt  (stat_pkt_cnt),
      .stat_err_cnt  (stat_err_cnt),
      .stat_drop_cnt (stat_drop_cnt),
      .stat_last_len (stat_last_len)
   );

   typedef struct {
      logic [63:0] data;
      logic        sop, eop, err;
      logic [2:0]  mod;
      logic        wr;     // word is expected to reach the output
      logic        drop;   // word bumps the drop counter
      logic        oerr;   // expected out_err if this is the last word
      logic [15:0] len;    // frame length in bytes (last word only)
   } mword_t;

   typedef struct packed {
      logic [63:0] data;
      logic        sop, eop, err;
      logic [2:0]  mod;
   } oword_t;

   mword_t      mac_q[$];
   oword_t      exp_q[$];
   mword_t      cur;
   int          n_chk = 0;
   int          n_fail = 0;
   int          occ = 0;
   int          n_out = 0;
   int          ready_mode = 0;
   int          ready_phase = 0;
   bit          avail_rand = 1'b0;
   logic [31:0] exp_pkt = 0, exp_err = 0, exp_drop = 0;
   logic [15:0] exp_last = 0;
   bit          hold = 1'b0;
   oword_t      held;
   oword_t      e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add_frame(input int nbytes, input bit e_in, input bit dup);
      int nw;
      nw = (nbytes + 7) / 8;
      for (int i = 0; i < nw; i++) begin
         mword_t w;
         w.data = {$urandom, $urandom};
         w.sop  = (i == 0);
         w.eop  = (i == nw - 1);
         w.err  = w.eop ? e_in : 1'($urandom);
         w.mod  = w.eop ? 3'(nbytes % 8) : 3'($urandom);
         w.wr   = 1'b1;
         w.drop = (i == 0) && dup;
         w.len  = 16'(nbytes);
         w.oerr = e_in || (nbytes < 64) || (nbytes > 1518);
         mac_q.push_back(w);
      end
   endtask

   task automatic add_partial(input int nw);
      for (int i = 0; i < nw; i++) begin
         mword_t w;
         w = '{default: '0};
         w.data = {$urandom, $urandom};
         w.sop  = (i == 0);
         w.wr   = 1'b1;
         mac_q.push_back(w);
      end
   endtask

   task automatic add_orphan();
      mword_t w;
      w = '{default: '0};
      w.data = {$urandom, $urandom};
      w.drop = 1'b1;
      mac_q.push_back(w);
   endtask

   // One clock: honour the read enable seen before the edge, then drive the next cycle.
   task automatic step();
      logic r;
      @(negedge clk);
      r = ren;
      @(posedge clk);
      #1;
      if (r && mac_q.size() != 0) begin
         oword_t o;
         cur     = mac_q.pop_front();
         rx_val  = 1'b1;
         rx_data = cur.data;
         rx_sop  = cur.sop;
         rx_eop  = cur.eop;
         rx_err  = cur.err;
         rx_mod  = cur.mod;
         if (cur.wr) begin
            o.data = cur.data;
            o.sop  = cur.sop;
            o.eop  = cur.eop;
            o.err  = cur.eop ? cur.oerr : 1'b0;
            o.mod  = cur.eop ? cur.mod : 3'd0;
            exp_q.push_back(o);
         end
      end else begin
         if (r && !reset) chk("ren_without_frame", 64'(r), 64'd0);
         cur     = '{default: '0};
         rx_val  = 1'b0;
         rx_data = {$urandom, $urandom};
         rx_sop  = 1'($urandom);
         rx_eop  = 1'($urandom);
         rx_err  = 1'($urandom);
         rx_mod  = 3'($urandom);
      end
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = (ready_phase % 3 == 0);
         default: out_ready = 1'($urandom);
      endcase
      ready_phase++;
      avail = (mac_q.size() != 0) && (!avail_rand || ($urandom % 3 != 0));
   endtask

   task automatic drain(input int budget);
      int k;
      k = 0;
      while ((mac_q.size() != 0 || exp_q.size() != 0 || rx_val) && k < budget) begin
         step();
         k++;
      end
      if (k >= budget) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain_timeout: %0d mac words and %0d output words left, expected 0",
                  mac_q.size(), exp_q.size());
      end
      repeat (3) step();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset  = 1'b1;
      rx_val = 1'b0;
      cur    = '{default: '0};
      mac_q.delete();
      @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data",  out_data, 64'd0);
      chk("rst_out_flags", 64'({out_sop, out_eop, out_err, out_mod}), 64'd0);
      chk("rst_ren",       64'(ren), 64'd0);
      chk("rst_pkt_cnt",   64'(stat_pkt_cnt), 64'd0);
      chk("rst_err_cnt",   64'(stat_err_cnt), 64'd0);
      chk("rst_drop_cnt",  64'(stat_drop_cnt), 64'd0);
      chk("rst_last_len",  64'(stat_last_len), 64'd0);
      reset = 1'b0;
   endtask

   // Scoreboard: checks outputs every cycle, then advances the model for the coming edge.
   always @(negedge clk) begin
      if (reset) begin
         occ      = 0;
         exp_q.delete();
         exp_pkt  = 0;
         exp_err  = 0;
         exp_drop = 0;
         exp_last = 0;
         hold     = 1'b0;
      end else begin
         chk("out_valid", 64'(out_valid), 64'(occ != 0));
         if (ren && (occ > DEPTH - 2 || (rx_val && rx_eop))) begin
            chk("ren_guard", 64'(ren), 64'd0);
         end
         if (hold) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_word", {out_data[63:6], out_data[5:0] ^ {out_sop, out_eop, out_err, out_mod}},
                {held.data[63:6], held.data[5:0] ^ {held.sop, held.eop, held.err, held.mod}});
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("spurious_word", 64'(out_valid), 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", out_data, e.data);
               chk("out_sop",  64'(out_sop), 64'(e.sop));
               chk("out_eop",  64'(out_eop), 64'(e.eop));
               chk("out_err",  64'(out_err), 64'(e.err));
               chk("out_mod",  64'(out_mod), 64'(e.mod));
               n_out++;
            end
         end
         hold = out_valid && !out_ready;
         held = '{out_data, out_sop, out_eop, out_err, out_mod};
         chk("stat_pkt_cnt",  64'(stat_pkt_cnt),  64'(exp_pkt));
         chk("stat_err_cnt",  64'(stat_err_cnt),  64'(exp_err));
         chk("stat_drop_cnt", 64'(stat_drop_cnt), 64'(exp_drop));
         chk("stat_last_len", 64'(stat_last_len), 64'(exp_last));
         if (rx_val && cur.wr && cur.eop) begin
            exp_pkt++;
            if (cur.oerr) exp_err++;
            exp_last = cur.len;
         end
         if (rx_val && cur.drop) exp_drop++;
         occ = occ + ((rx_val && cur.wr) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      reset     = 1'b1;
      avail     = 1'b0;
      rx_val    = 1'b0;
      rx_data   = 64'd0;
      rx_sop    = 1'b0;
      rx_eop    = 1'b0;
      rx_err    = 1'b0;
      rx_mod    = 3'd0;
      out_ready = 1'b1;
      cur       = '{default: '0};
      do_reset();

      base = n_out;
      add_frame(64, 1'b0, 1'b0);
      drain(400);
      chk("f64_words",    64'(n_out - base), 64'd8);
      chk("f64_pkt_cnt",  64'(stat_pkt_cnt), 64'd1);
      chk("f64_err_cnt",  64'(stat_err_cnt), 64'd0);
      chk("f64_last_len", 64'(stat_last_len), 64'd64);

      add_frame(60, 1'b0, 1'b0);
      drain(400);
      chk("f60_err_cnt",  64'(stat_err_cnt), 64'd1);
      chk("f60_last_len", 64'(stat_last_len), 64'd60);

      add_frame(1519, 1'b0, 1'b0);
      drain(2000);
      chk("f1519_err_cnt",  64'(stat_err_cnt), 64'd2);
      chk("f1519_last_len", 64'(stat_last_len), 64'd1519);

      ready_mode = 1;
      base = n_out;
      add_frame(1518, 1'b0, 1'b0);
      drain(3000);
      chk("f1518_words",    64'(n_out - base), 64'd190);
      chk("f1518_err_cnt",  64'(stat_err_cnt), 64'd2);
      chk("f1518_last_len", 64'(stat_last_len), 64'd1518);
      ready_mode = 0;

      add_frame(100, 1'b1, 1'b0);
      drain(400);
      chk("f100_err_cnt",  64'(stat_err_cnt), 64'd3);
      chk("f100_last_len", 64'(stat_last_len), 64'd100);
      chk("f100_pkt_cnt",  64'(stat_pkt_cnt), 64'd5);

      base = n_out;
      add_orphan();
      add_partial(3);
      add_frame(64, 1'b0, 1'b1);
      drain(400);
      chk("dup_drop_cnt", 64'(stat_drop_cnt), 64'd2);
      chk("dup_pkt_cnt",  64'(stat_pkt_cnt), 64'd6);
      chk("dup_words",    64'(n_out - base), 64'd11);

      add_frame(80, 1'b0, 1'b0);
      while (mac_q.size() > 5) step();
      do_reset();
      add_frame(64, 1'b0, 1'b0);
      drain(400);
      chk("post_rst_pkt_cnt",  64'(stat_pkt_cnt), 64'd1);
      chk("post_rst_last_len", 64'(stat_last_len), 64'd64);
      chk("post_rst_drop_cnt", 64'(stat_drop_cnt), 64'd0);

      ready_mode = 2;
      avail_rand = 1'b1;
      for (int f = 0; f < 25; f++) begin
         if ($urandom % 8 == 0) add_orphan();
         add_frame(int'($urandom_range(1, 1600)), ($urandom % 5 == 0), 1'b0);
      end
      drain(20000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
